pif_to_posit_pipe: RTL and testbench



---
 rtl/pif_to_posit_pipe.sv | 184 ++++++++++++++++++
 tb/tb_pif_to_posit_pipe.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pif_to_posit_pipe.sv
// pif_to_posit_pipe
// Two-stage pipelined encoder from posit intermediate format {sign, te, mant}
// back to an N-bit posit, with valid/ready handshakes on both sides.
//
// Optional feature macro: PIF_TO_POSIT_ROUND_EN
//   defined   -> round to nearest, ties to even (guard/sticky carried in stage 1)
//   undefined -> truncate
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   input word valid
//   in_ready   out  input accepted this cycle (combinational from out_ready)
//   pif        in   {sign, te, mant}, PIF_SIZE bits
//   is_zero    in   input is zero (pif ignored)
//   is_nar     in   input is NaR (priority over is_zero)
//   out_valid  out  posit valid
//   out_ready  in   consumer takes posit this cycle
//   posit      out  encoded N-bit posit
module pif_to_posit_pipe #(
  parameter  int N         = 16,
  parameter  int ES        = 1,
  localparam int TE_SIZE   = ES + $clog2(N) + 1,
  localparam int MANT_SIZE = N - 2,
  localparam int PIF_SIZE  = 1 + TE_SIZE + MANT_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIF_SIZE-1:0] pif,
  input  logic                is_zero,
  input  logic                is_nar,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        posit
);

  localparam int FRAC_W = N - 3;          // mantissa without hidden bit
  localparam int BASE_W = N - 1 + ES;     // regime seed (2 bits) + e + fraction
  localparam int PAD_W  = N - 2;          // room for bits shifted past the body
  localparam int EXT_W  = BASE_W + PAD_W;

  // ---------------- field split and regime construction ----------------
  logic                        in_sign;
  logic signed [TE_SIZE-1:0]   te;
  logic signed [TE_SIZE-1:0]   k;
  logic [MANT_SIZE-1:0]        mant;
  logic [BASE_W-1:0]           base;
  logic [TE_SIZE-1:0]          shamt;
  logic signed [EXT_W-1:0]     ext;
  logic signed [31:0]          k_ext;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [N-2:0]                body_next;

  assign {in_sign, te, mant} = pif;
  assign k = te >>> ES;

  // Seed is {lead, ~lead, e, frac}. An arithmetic right shift replicates lead,
  // so k >= 0 shifted by k yields k+1 ones then a zero, and k < 0 shifted by
  // -k-1 (= ~k) yields -k zeros then a one.
  generate
    if (ES > 0) begin : g_es
      assign base = {~k[TE_SIZE-1], k[TE_SIZE-1], te[ES-1:0], mant[FRAC_W-1:0]};
    end else begin : g_no_es
      assign base = {~k[TE_SIZE-1], k[TE_SIZE-1], mant[FRAC_W-1:0]};
    end
  endgenerate

  assign shamt  = k[TE_SIZE-1] ? ~k : k;
  assign ext    = $signed({base, {PAD_W{1'b0}}}) >>> shamt;
  assign k_ext  = 32'(k);
  assign sat_hi = (k_ext >= (N - 2));
  assign sat_lo = (k_ext <= -(N - 2));

  // Saturated cases are resolved here; the sat flag then suppresses rounding.
  always_comb begin
    body_next = ext[EXT_W-1 -: N-1];
    if (sat_hi)
      body_next = {(N-1){1'b1}};
    else if (sat_lo)
      body_next = {{(N-2){1'b0}}, 1'b1};
  end

  // ---------------- handshake ----------------
  logic v1_reg;
  logic v2_reg;
  logic s2_load;
  logic s1_load;

  assign s2_load   = ~v2_reg | out_ready;
  assign s1_load   = ~v1_reg | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2_reg;

  // ---------------- stage 1 ----------------
  logic         s1_sign_reg;
  logic         s1_nar_reg;
  logic         s1_zero_reg;
  logic         s1_sat_reg;
  logic [N-2:0] s1_body_reg;
`ifdef PIF_TO_POSIT_ROUND_EN
  logic         s1_guard_reg;
  logic         s1_sticky_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg        <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_nar_reg    <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_sat_reg    <= 1'b0;
      s1_body_reg   <= '0;
`ifdef PIF_TO_POSIT_ROUND_EN
      s1_guard_reg  <= 1'b0;
      s1_sticky_reg <= 1'b0;
`endif
    end else if (s1_load) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        s1_sign_reg   <= in_sign;
        s1_nar_reg    <= is_nar;
        s1_zero_reg   <= is_zero;
        s1_sat_reg    <= sat_hi | sat_lo;
        s1_body_reg   <= body_next;
`ifdef PIF_TO_POSIT_ROUND_EN
        s1_guard_reg  <= ext[EXT_W-N];
        s1_sticky_reg <= |ext[EXT_W-N-1:0];
`endif
      end
    end
  end

  // ---------------- stage 2 combinational: round, sign, specials ----------------
  logic [N-2:0] body_rnd;
  logic [N-1:0] mag;
  logic [N-1:0] result;

`ifdef PIF_TO_POSIT_ROUND_EN
  logic         round_up;
  logic [N-1:0] body_sum;
  logic         unused_bits;

  assign round_up    = s1_guard_reg & (s1_sticky_reg | s1_body_reg[0]) & ~s1_sat_reg;
  assign body_sum    = {1'b0, s1_body_reg} + N'(round_up);
  // A carry out of an all-ones body clamps at maxpos instead of wrapping.
  assign body_rnd    = body_sum[N-1] ? {(N-1){1'b1}} : body_sum[N-2:0];
  assign unused_bits = mant[MANT_SIZE-1];
`else
  logic unused_bits;

  assign body_rnd    = s1_body_reg;
  assign unused_bits = ^{mant[MANT_SIZE-1], ext[EXT_W-N:0], s1_sat_reg};
`endif

  assign mag = {1'b0, body_rnd};

  always_comb begin
    result = s1_sign_reg ? (~mag + 1'b1) : mag;
    if (s1_nar_reg)
      result = {1'b1, {(N-1){1'b0}}};
    else if (s1_zero_reg)
      result = '0;
  end

  // ---------------- stage 2 register ----------------
  logic [N-1:0] posit_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg    <= 1'b0;
      posit_reg <= '0;
    end else if (s2_load) begin
      v2_reg <= v1_reg;
      if (v1_reg)
        posit_reg <= result;
    end
  end

  assign posit = posit_reg;

endmodule

// File: tb/tb_pif_to_posit_pipe.sv
// Directed self-checking bench for pif_to_posit_pipe at N=8, ES=0
// (TE_SIZE=4, MANT_SIZE=6, PIF_SIZE=11). Expected values are hand-computed.
module tb_pif_to_posit_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] pif;
  logic        is_zero;
  logic        is_nar;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  posit;

  int errors = 0;
  int checks = 0;

  pif_to_posit_pipe #(.N(8), .ES(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pif       (pif),
    .is_zero   (is_zero),
    .is_nar    (is_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .posit     (posit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one word with out_ready high, checks 2-cycle latency and the value.
  // Entered and left at posedge+1.
  task automatic run_one(input string tag, input logic s, input logic [3:0] te,
                         input logic [5:0] m, input logic z, input logic n,
                         input logic [7:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pif       = {s, te, m};
    is_zero   = z;
    is_nar    = n;
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    pif      = 11'h5A5;   // must not matter after accept
    is_zero  = 1'b0;
    is_nar   = 1'b0;
    @(negedge clk);
    check({tag, "/lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "/lat2_valid"}, 32'(out_valid), 32'd1);
    check({tag, "/posit"}, 32'(posit), 32'(exp));
    $display("txn %s: posit=%02h expected=%02h", tag, posit, exp);
    @(posedge clk); #1;
  endtask

  logic [10:0] bp_pif [6];
  logic [7:0]  bp_exp [6];

  initial begin
    int sent;
    int recv;
    logic stalled_prev;
    logic saw_block;
    logic acc;
    logic [7:0] held;

    rst = 1'b1; in_valid = 1'b0; pif = '0; is_zero = 1'b0; is_nar = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/posit", 32'(posit), 32'h00);
    check("reset/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Basic values
    run_one("te0_m100000",   1'b0, 4'h0, 6'b100000, 1'b0, 1'b0, 8'h40);
    run_one("te1_m110000",   1'b0, 4'h1, 6'b110000, 1'b0, 1'b0, 8'h68);
    run_one("neg_te1_m110000", 1'b1, 4'h1, 6'b110000, 1'b0, 1'b0, 8'h98);
    // Rounding
`ifdef PIF_TO_POSIT_ROUND_EN
    run_one("rnd_te1_m101111", 1'b0, 4'h1, 6'b101111, 1'b0, 1'b0, 8'h68);
    run_one("tie_te1_m101101", 1'b0, 4'h1, 6'b101101, 1'b0, 1'b0, 8'h66);
    run_one("te5_m111111",     1'b0, 4'h5, 6'b111111, 1'b0, 1'b0, 8'h7F);
`else
    run_one("trunc_te1_m101111", 1'b0, 4'h1, 6'b101111, 1'b0, 1'b0, 8'h67);
    run_one("trunc_te1_m101101", 1'b0, 4'h1, 6'b101101, 1'b0, 1'b0, 8'h66);
    run_one("trunc_te5_m111111", 1'b0, 4'h5, 6'b111111, 1'b0, 1'b0, 8'h7E);
`endif
    // Saturation
    run_one("sat_te7",     1'b0, 4'h7, 6'b101010, 1'b0, 1'b0, 8'h7F);
    run_one("sat_te-7",    1'b0, 4'h9, 6'b111111, 1'b0, 1'b0, 8'h01);
    run_one("sat_neg_te7", 1'b1, 4'h7, 6'b100000, 1'b0, 1'b0, 8'h81);
    // Specials
    run_one("nar_and_zero", 1'b0, 4'h1, 6'b110000, 1'b1, 1'b1, 8'h80);
    run_one("zero",         1'b1, 4'h3, 6'b111111, 1'b1, 1'b0, 8'h00);

    // Backpressure: 6 words, out_ready low for cycles 3..7
    for (int i = 0; i < 6; i++)
      bp_pif[i] = {1'b0, 4'h0, 1'b1, 5'(i * 3 + 1)};
    bp_exp = '{8'h41, 8'h44, 8'h47, 8'h4A, 8'h4D, 8'h50};
    sent = 0; recv = 0; stalled_prev = 1'b0; saw_block = 1'b0; held = '0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (sent < 6);
      pif       = (sent < 6) ? bp_pif[sent] : 11'h000;
      @(negedge clk);
      if (stalled_prev) begin
        check($sformatf("bp_hold_valid_c%0d", c), 32'(out_valid), 32'd1);
        check($sformatf("bp_hold_posit_c%0d", c), 32'(posit), 32'(held));
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("bp_word%0d", recv), 32'(posit), 32'(bp_exp[recv]));
        $display("txn bp_word%0d: posit=%02h expected=%02h", recv, posit, bp_exp[recv]);
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      held = posit;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    check("bp_count", 32'(recv), 32'd6);
    check("bp_in_ready_dropped", 32'(saw_block), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("bp_no_dup_c%0d", c), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Reset mid-stream with two words in flight
    out_ready = 1'b1;
    in_valid  = 1'b1; pif = {1'b0, 4'h0, 6'b100000};
    @(posedge clk); #1;
    pif = {1'b0, 4'h1, 6'b110000};
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_pre/out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/posit", 32'(posit), 32'h00);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    $display("txn reset_midstream: out_valid=%0d posit=%02h", out_valid, posit);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("rst_discard_c%0d", c), 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
